// File: rtl/fetch_queue_pkg.sv
// rtl/fetch_queue_pkg.sv - shared defaults and control-word indices for the fetch queue
package fetch_queue_pkg;

  localparam int FQ_DEPTH = 4;
  localparam int FQ_W     = 32;

  // Control-word bit positions for taken jump and branch, used to build flush.
  localparam int CTRL_W = 16;
  localparam int JP_IDX = 5;
  localparam int BR_IDX = 6;

  function automatic logic fq_flush(input logic [CTRL_W-1:0] ctrl, input logic taken);
    return ctrl[JP_IDX] | (ctrl[BR_IDX] & taken);
  endfunction

endpackage

// File: rtl/fq_storage.sv
// rtl/fq_storage.sv - register-array RAM, one write port, one asynchronous read port
module fq_storage #(
  parameter int DEPTH = 4,
  parameter int DW    = 64
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [DW-1:0]            wdata,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [DW-1:0]            rdata
);

  logic [DW-1:0] mem [DEPTH];

  // Contents are not reset; the pointers and count define what is valid.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/fetch_queue.sv
// rtl/fetch_queue.sv - in-order fetch-to-decode instruction queue with flush and back-pressure
module fetch_queue
  import fetch_queue_pkg::*;
#(
  parameter int DEPTH = FQ_DEPTH,
  parameter int W     = FQ_W
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  input  logic [W-1:0]           in_pc,
  input  logic [W-1:0]           in_insn,
  input  logic                   flush,
  output logic                   fetch_stall,
  output logic                   out_valid,
  output logic [W-1:0]           out_pc,
  output logic [W-1:0]           out_insn,
  input  logic                   out_ready,
  output logic [$clog2(DEPTH):0] count,
  output logic                   overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT  = (AW+1)'(DEPTH);
  localparam logic [AW:0] STALL_CNT = (AW+1)'(DEPTH - 1);

  logic [AW-1:0]  wr_ptr, rd_ptr;
  logic [2*W-1:0] rdata;
  logic           push, pop, drop;

  assign out_valid = (count != '0);
  assign pop  = out_valid & out_ready & ~flush;
  assign push = in_valid & ~flush & ((count < FULL_CNT) | pop);
  assign drop = in_valid & ~flush & (count == FULL_CNT) & ~pop;

  // Threshold leaves room for the word already in flight from the one-cycle memory.
  assign fetch_stall = (count >= STALL_CNT);

  assign out_pc   = out_valid ? rdata[2*W-1:W] : '0;
  assign out_insn = out_valid ? rdata[W-1:0]   : '0;

  fq_storage #(.DEPTH(DEPTH), .DW(2*W)) u_storage (
    .clk   (clk),
    .we    (push),
    .waddr (wr_ptr),
    .wdata ({in_pc, in_insn}),
    .raddr (rd_ptr),
    .rdata (rdata)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (drop) overflow <= 1'b1;
      if (flush) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        count  <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + AW'(1);
        if (pop)  rd_ptr <= rd_ptr + AW'(1);
        case ({push, pop})
          2'b10:   count <= count + (AW+1)'(1);
          2'b01:   count <= count - (AW+1)'(1);
          default: count <= count;
        endcase
      end
    end
  end

endmodule
